// File: rtl/bf_program_loader.sv
// rtl/bf_program_loader.sv - Brainfuck source loader writing encoded opcodes into core program memory
module bf_program_loader #(
    parameter int INSTR_WIDTH       = 3,
    parameter int PRGMEM_ADDR_WIDTH = 8,
    parameter int STACK_ADDR_WIDTH  = 4
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_start,
    input  logic [7:0]                   i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic                         o_prgmem_in,
    output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
    output logic [INSTR_WIDTH-1:0]       o_prgmem_data,
    output logic [PRGMEM_ADDR_WIDTH:0]   o_length,
    output logic                         o_core_hold,
    output logic                         o_done,
    output logic                         o_error,
    output logic [1:0]                   o_error_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [INSTR_WIDTH-1:0] OP_NOP   = INSTR_WIDTH'(3'b000);
    localparam logic [INSTR_WIDTH-1:0] OP_INC   = INSTR_WIDTH'(3'b010);
    localparam logic [INSTR_WIDTH-1:0] OP_DEC   = INSTR_WIDTH'(3'b011);
    localparam logic [INSTR_WIDTH-1:0] OP_RIGHT = INSTR_WIDTH'(3'b100);
    localparam logic [INSTR_WIDTH-1:0] OP_LEFT  = INSTR_WIDTH'(3'b101);
    localparam logic [INSTR_WIDTH-1:0] OP_OPEN  = INSTR_WIDTH'(3'b110);
    localparam logic [INSTR_WIDTH-1:0] OP_CLOSE = INSTR_WIDTH'(3'b111);

    localparam logic [PRGMEM_ADDR_WIDTH:0] CNT_ONE   = {{PRGMEM_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [STACK_ADDR_WIDTH:0]  DEPTH_ONE = {{STACK_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [STACK_ADDR_WIDTH:0]  DEPTH_MAX = {1'b1, {STACK_ADDR_WIDTH{1'b0}}};

    state_t                         r_state;
    state_t                         w_state_next;
    logic [PRGMEM_ADDR_WIDTH:0]     r_count;
    logic [STACK_ADDR_WIDTH:0]      r_depth;
    logic                           r_prgmem_in;
    logic [PRGMEM_ADDR_WIDTH-1:0]   r_prgmem_addr;
    logic [INSTR_WIDTH-1:0]         r_prgmem_data;
    logic [PRGMEM_ADDR_WIDTH:0]     r_length;
    logic [1:0]                     r_error_code;

    logic                           w_is_bf;
    logic [INSTR_WIDTH-1:0]         w_opcode;
    logic                           w_wr;
    logic                           w_fill_wr;
    logic                           w_clear;
    logic                           w_term;
    logic                           w_err_set;
    logic [1:0]                     w_err_code;

    always_comb begin
        w_is_bf  = 1'b1;
        w_opcode = OP_NOP;
        case (i_data)
            8'h2B:   w_opcode = OP_INC;
            8'h2D:   w_opcode = OP_DEC;
            8'h3E:   w_opcode = OP_RIGHT;
            8'h3C:   w_opcode = OP_LEFT;
            8'h5B:   w_opcode = OP_OPEN;
            8'h5D:   w_opcode = OP_CLOSE;
            default: w_is_bf = 1'b0;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wr         = 1'b0;
        w_fill_wr    = 1'b0;
        w_clear      = 1'b0;
        w_term       = 1'b0;
        w_err_set    = 1'b0;
        w_err_code   = 2'b00;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_state_next = S_LOAD;
                    w_clear      = 1'b1;
                end
            end
            S_LOAD: begin
                if (i_valid) begin
                    if (i_data == 8'h00) begin
                        if (r_depth != '0) begin
                            w_err_set  = 1'b1;
                            w_err_code = 2'b11;
                        end else begin
                            w_term       = 1'b1;
                            w_state_next = S_FILL;
                        end
                    end else if (w_is_bf) begin
                        if (w_opcode == OP_CLOSE && r_depth == '0) begin
                            w_err_set  = 1'b1;
                            w_err_code = 2'b01;
                        end else if (w_opcode == OP_OPEN && r_depth == DEPTH_MAX) begin
                            w_err_set  = 1'b1;
                            w_err_code = 2'b10;
                        end else if (r_count[PRGMEM_ADDR_WIDTH]) begin
                            w_err_set  = 1'b1;
                            w_err_code = 2'b11;
                        end else begin
                            w_wr = 1'b1;
                        end
                    end
                    if (w_err_set) begin
                        w_state_next = S_ERROR;
                    end
                end
            end
            S_FILL: begin
                // Counter MSB set means the top address has already been written.
                if (r_count[PRGMEM_ADDR_WIDTH]) begin
                    w_state_next = S_DONE;
                end else begin
                    w_fill_wr = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count       <= '0;
            r_depth       <= '0;
            r_prgmem_in   <= 1'b0;
            r_prgmem_addr <= '0;
            r_prgmem_data <= '0;
            r_length      <= '0;
            r_error_code  <= 2'b00;
        end else begin
            r_prgmem_in <= w_wr | w_fill_wr;
            if (w_clear) begin
                r_count      <= '0;
                r_depth      <= '0;
                r_length     <= '0;
                r_error_code <= 2'b00;
            end
            if (w_wr) begin
                r_prgmem_addr <= r_count[PRGMEM_ADDR_WIDTH-1:0];
                r_prgmem_data <= w_opcode;
                r_count       <= r_count + CNT_ONE;
                if (w_opcode == OP_OPEN) begin
                    r_depth <= r_depth + DEPTH_ONE;
                end else if (w_opcode == OP_CLOSE) begin
                    r_depth <= r_depth - DEPTH_ONE;
                end
            end
            if (w_fill_wr) begin
                r_prgmem_addr <= r_count[PRGMEM_ADDR_WIDTH-1:0];
                r_prgmem_data <= OP_NOP;
                r_count       <= r_count + CNT_ONE;
            end
            if (w_term) begin
                r_length <= r_count;
            end
            if (w_err_set) begin
                r_error_code <= w_err_code;
            end
        end
    end

    assign o_ready       = (r_state == S_LOAD);
    assign o_prgmem_in   = r_prgmem_in;
    assign o_prgmem_addr = r_prgmem_addr;
    assign o_prgmem_data = r_prgmem_data;
    assign o_length      = r_length;
    assign o_core_hold   = (r_state != S_DONE);
    assign o_done        = (r_state == S_DONE);
    assign o_error       = (r_state == S_ERROR);
    assign o_error_code  = r_error_code;

endmodule

// File: tb/tb_bf_program_loader.sv
// tb/tb_bf_program_loader.sv - scoreboard bench for bf_program_loader
module tb_bf_program_loader;

    logic       i_clock;
    logic       i_reset_n;
    logic       i_start;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_prgmem_in;
    logic [7:0] o_prgmem_addr;
    logic [2:0] o_prgmem_data;
    logic [8:0] o_length;
    logic       o_core_hold;
    logic       o_done;
    logic       o_error;
    logic [1:0] o_error_code;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];

    bit m_loading;
    int m_count;
    int m_depth;
    int m_len;
    int m_err;

    bf_program_loader dut (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .i_start       (i_start),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_prgmem_in   (o_prgmem_in),
        .o_prgmem_addr (o_prgmem_addr),
        .o_prgmem_data (o_prgmem_data),
        .o_length      (o_length),
        .o_core_hold   (o_core_hold),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_error_code  (o_error_code)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge i_clock) begin
        if (i_reset_n && o_prgmem_in) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, o_prgmem_in}, 32'd0);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {24'd0, o_prgmem_addr}, {24'd0, e[10:3]});
                check("wr_data", {29'd0, o_prgmem_data}, {29'd0, e[2:0]});
            end
        end
    end

    function automatic int encode(input logic [7:0] b);
        case (b)
            "+":     return 2;
            "-":     return 3;
            ">":     return 4;
            "<":     return 5;
            "[":     return 6;
            "]":     return 7;
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int op;
        op = encode(b);
        if (b == 8'h00) begin
            if (m_depth != 0) begin
                m_err = 3; m_loading = 1'b0;
            end else begin
                m_len = m_count;
                for (int a = m_count; a < 256; a++) exp_q.push_back({a[7:0], 3'b000});
                m_loading = 1'b0;
            end
        end else if (op >= 0) begin
            if (op == 7 && m_depth == 0) begin
                m_err = 1; m_loading = 1'b0;
            end else if (op == 6 && m_depth == 16) begin
                m_err = 2; m_loading = 1'b0;
            end else if (m_count == 256) begin
                m_err = 3; m_loading = 1'b0;
            end else begin
                exp_q.push_back({m_count[7:0], op[2:0]});
                m_count++;
                if (op == 6) m_depth++;
                if (op == 7) m_depth--;
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        i_data  = b;
        i_valid = 1'b1;
        check("ready", {31'd0, o_ready}, {31'd0, m_loading});
        if (m_loading) model_byte(b);
        @(posedge i_clock);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_start();
        i_start = 1'b1;
        @(posedge i_clock);
        #1;
        i_start = 1'b0;
        m_loading = 1'b1; m_count = 0; m_depth = 0; m_err = 0; m_len = 0;
        check("start_ready", {31'd0, o_ready}, 32'd1);
        check("start_hold", {31'd0, o_core_hold}, 32'd1);
        check("start_err", {31'd0, o_error}, 32'd0);
        check("start_code", {30'd0, o_error_code}, 32'd0);
        check("start_len", {23'd0, o_length}, 32'd0);
    endtask

    task automatic wait_done(input bit expect_prev255);
        bit prev255;
        int n;
        prev255 = 1'b0;
        n = 0;
        while (n < 600) begin
            @(negedge i_clock);
            if (o_done) break;
            prev255 = o_prgmem_in && (o_prgmem_addr == 8'hFF);
            n++;
        end
        check("done_reached", {31'd0, o_done}, 32'd1);
        check("done_hold", {31'd0, o_core_hold}, 32'd0);
        check("done_after_255", {31'd0, prev255}, {31'd0, expect_prev255});
        check("done_len", {23'd0, o_length}, m_len);
        check("queue_empty", exp_q.size(), 32'd0);
        @(posedge i_clock);
        #1;
    endtask

    task automatic expect_error();
        check("err_flag", {31'd0, o_error}, 32'd1);
        check("err_code", {30'd0, o_error_code}, m_err);
        check("err_hold", {31'd0, o_core_hold}, 32'd1);
        check("err_ready", {31'd0, o_ready}, 32'd0);
        @(negedge i_clock);
        #1;
        check("err_queue_empty", exp_q.size(), 32'd0);
        @(posedge i_clock);
        #1;
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_start   = 1'b0;
        i_valid   = 1'b0;
        i_data    = 8'h00;
        m_loading = 1'b0;
        m_count = 0; m_depth = 0; m_err = 0; m_len = 0;
        repeat (3) @(posedge i_clock);
        #1;
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_wr", {31'd0, o_prgmem_in}, 32'd0);
        check("rst_addr", {24'd0, o_prgmem_addr}, 32'd0);
        check("rst_data", {29'd0, o_prgmem_data}, 32'd0);
        check("rst_len", {23'd0, o_length}, 32'd0);
        check("rst_hold", {31'd0, o_core_hold}, 32'd1);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {31'd0, o_error}, 32'd0);
        check("rst_code", {30'd0, o_error_code}, 32'd0);
        i_reset_n = 1'b1;
        @(posedge i_clock);
        #1;

        do_start();
        send_str("+[->+<]");
        send(8'h00);
        wait_done(1'b1);
        send("+");

        do_start();
        send_str("a+ b\n-");
        send(8'h00);
        wait_done(1'b1);

        do_start();
        send("]");
        expect_error();
        send("+");
        do_start();
        send(8'h00);
        wait_done(1'b1);

        do_start();
        for (int i = 0; i < 17; i++) send("[");
        expect_error();

        do_start();
        send_str("[[");
        send(8'h00);
        expect_error();

        do_start();
        for (int i = 0; i < 256; i++) send("+");
        send(8'h00);
        wait_done(1'b0);

        do_start();
        for (int i = 0; i < 257; i++) send("+");
        expect_error();

        do_start();
        send_str("+++");
        @(negedge i_clock);
        #1;
        i_reset_n = 1'b0;
        m_loading = 1'b0;
        #1;
        check("arst_wr", {31'd0, o_prgmem_in}, 32'd0);
        check("arst_ready", {31'd0, o_ready}, 32'd0);
        check("arst_addr", {24'd0, o_prgmem_addr}, 32'd0);
        check("arst_hold", {31'd0, o_core_hold}, 32'd1);
        check("arst_queue_empty", exp_q.size(), 32'd0);
        @(posedge i_clock);
        #1;
        i_reset_n = 1'b1;
        @(posedge i_clock);
        #1;
        check("post_rst_ready", {31'd0, o_ready}, 32'd0);
        check("post_rst_done", {31'd0, o_done}, 32'd0);
        send("+");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bf_program_loader.md
Name: bf_program_loader

Overview:
- Writer side of the program-memory interface that the brainhack core reads.
- Accepts an ASCII Brainfuck source stream over a valid/ready byte handshake and discards every non-BF character.
- Encodes each BF character to the core's 3-bit opcode and writes it to program memory. Clears the remaining program memory and checks bracket balance against the core's stack depth.
- Holds the core stalled (o_core_hold) until a program has loaded successfully.

Parameters:
- INSTR_WIDTH, 3, opcode width; must match the core.
- PRGMEM_ADDR_WIDTH, 8, program memory address width; capacity is 2^PRGMEM_ADDR_WIDTH = 256 opcodes.
- STACK_ADDR_WIDTH, 4, core stack address width; maximum bracket nesting is 2^STACK_ADDR_WIDTH = 16.

Ports:
- i_clock, input, 1, system clock; all state changes on the rising edge.
- i_reset_n, input, 1, asynchronous active-low reset.
- i_start, input, 1, one-cycle pulse that begins a new load; honoured in IDLE, DONE and ERROR only.
- i_data, input, 8, source byte in ASCII.
- i_valid, input, 1, i_data is valid.
- o_ready, output, 1, loader accepts a byte this cycle.
- o_prgmem_in, output, 1, program memory write enable (registered).
- o_prgmem_addr, output, PRGMEM_ADDR_WIDTH, write address (registered).
- o_prgmem_data, output, INSTR_WIDTH, opcode to write (registered).
- o_length, output, PRGMEM_ADDR_WIDTH+1, number of opcodes stored.
- o_core_hold, output, 1, holds the core stalled and its PC at 0 while high.
- o_done, output, 1, load completed successfully.
- o_error, output, 1, load failed.
- o_error_code, output, 2, 00 none, 01 unmatched ']', 02 nesting overflow, 03 encoded below.
  - 2'b00 = none; 2'b01 = unmatched ']'; 2'b10 = nesting > 16; 2'b11 = program > 256 ops or unclosed '['.

Behaviour:
- Reset (asynchronous, active-low): state IDLE.
  - o_ready=0, o_prgmem_in=0, o_prgmem_addr=0, o_prgmem_data=0, o_length=0.
  - o_core_hold=1, o_done=0, o_error=0, o_error_code=0.
  - Reset asserted mid-load aborts the load immediately. Partial memory contents are left as written.
- Encoding:
  - '+'=3'b010, '-'=3'b011, '>'=3'b100, '<'=3'b101, '['=3'b110, ']'=3'b111.
  - Every other byte is accepted and dropped, with no write and no count change.
  - Byte 0x00 is the end-of-program terminator.
- States:
  - IDLE: o_ready=0. On i_start go to LOAD; clear the write counter, depth counter, o_length and the error fields.
  - LOAD: o_ready=1. A byte is accepted when i_valid && o_ready. For an accepted BF character:
    - On the next cycle, o_prgmem_in=1, o_prgmem_addr=counter, o_prgmem_data=opcode.
    - The counter increments (PRGMEM_ADDR_WIDTH+1 bits, so it does not wrap).
    - Sustained throughput is 1 byte per cycle; write latency is 1 cycle after acceptance.
  - FILL: o_ready=0. Write 3'b000 (NOP) at addresses o_length .. 2^PRGMEM_ADDR_WIDTH-1, one per cycle. Go to DONE after the write to the last address. If o_length=256, pass through FILL in 0 write cycles.
  - DONE: o_done=1, o_core_hold=0. Hold until i_start or reset.
  - ERROR: o_error=1, o_core_hold=1, o_error_code is held, o_ready=0. Hold until i_start or reset. No further writes occur.
- Bracket depth: counter of STACK_ADDR_WIDTH+1 bits, updated on acceptance.
  - '[' increments the depth.
  - ']' decrements the depth.
  - ']' at depth 0: no write; go to ERROR with code 01.
  - '[' at depth 16: no write; go to ERROR with code 10.
- Capacity: a BF character accepted when the counter is 256 causes no write and goes to ERROR with code 11.
- Terminator 0x00:
  - depth != 0: go to ERROR with code 11.
  - Otherwise: o_length is latched from the counter and the state becomes FILL.
  - The last program write, if any, completes in the first FILL cycle. FILL addressing starts only after it, so there is no write collision.
- o_core_hold is 1 in every state except DONE. i_start in DONE reasserts it on the next cycle.
- i_start in LOAD or FILL is ignored.
- i_valid while o_ready=0 is ignored; no byte is consumed.

Test Plan:
1. Reset, i_start, stream "+[->+<]" then 0x00 -> writes 010,110,011,100,010,101,111 at addresses 0..6; o_length=7; NOP written at 7..255; o_done=1 and o_core_hold=0 on the cycle after the address-255 write.
2. Stream "a+ b\n-" then 0x00 -> only addresses 0,1 written (010,011); o_length=2.
3. Stream "]" -> no write, o_error=1, o_error_code=01, o_core_hold=1; a following i_start returns to LOAD with error fields cleared.
4. Stream 17×'[' -> 16 writes of 110; the 17th '[' gives o_error_code=10. Separately, "[[" then 0x00 -> o_error_code=11.
5. Stream 256×'+' then 0x00 -> 256 writes, FILL issues 0 writes, o_length=256, o_done=1. A 257th '+' instead gives o_error_code=11.
6. Drop i_reset_n mid-LOAD after 3 writes -> all outputs take reset values asynchronously; o_prgmem_in=0 in the same cycle; state is IDLE after release.
